mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 144 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO at 0x0, STATUS/overflow-clear at 0x4, 8N1 serializer.
// Loads return one cycle after bus_re; stores to a full FIFO are dropped and flagged as overflow.
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        uart_tx,
  output logic        tx_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          overflow;

  logic        fifo_full;
  logic        fifo_empty;
  logic        wr_txdata;
  logic        wr_status;
  logic        push;
  logic        pop;
  logic        baud_done;
  logic [31:0] status;

  // Full is judged on the pre-edge count, so a pop in the same cycle never frees room for a write.
  assign fifo_full  = fifo_cnt == CW'(FIFO_DEPTH);
  assign fifo_empty = fifo_cnt == '0;
  assign wr_txdata  = bus_we && (bus_addr == 4'h0);
  assign wr_status  = bus_we && (bus_addr == 4'h4);
  assign push       = wr_txdata && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign baud_done  = baud_cnt == BAUD_LAST;
  assign status     = {16'h0, 8'(fifo_cnt), 4'h0, overflow, state != IDLE, fifo_empty, fifo_full};
  assign tx_irq     = fifo_empty && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr] <= bus_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      overflow  <= 1'b0;
      bus_rdata <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CW'(1);
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - CW'(1);
      end
      if (wr_txdata && fifo_full) begin
        overflow <= 1'b1;
      end else if (wr_status && bus_wdata[3]) begin
        overflow <= 1'b0;
      end
      if (bus_re) begin
        bus_rdata <= (bus_addr == 4'h4) ? status : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx  <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            uart_tx   <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            uart_tx  <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            // Shifting right keeps the next bit to send at shift_reg[1] after each bit period.
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              uart_tx   <= shift_reg[1];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level model (queue + cycle position in frame) checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_mmio_uart_tx;
  localparam int C = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [3:0]  bus_addr = 4'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic        uart_tx;
  logic        tx_irq;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  mmio_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .uart_tx(uart_tx), .tx_irq(tx_irq)
  );

  always #5 clk = ~clk;

  // Model: a frame is 10*C cycles indexed by pos; symbol = pos / C (start, 8 data LSB first, stop).
  logic [7:0]  q[$];
  bit          act = 1'b0;
  int          pos = 0;
  logic [7:0]  cur = 8'h0;
  bit          ovf = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  bit          was_full;
  bit          can_pop;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s       = 32'h0;
    s[15:8] = 8'(q.size());
    s[3]    = ovf;
    s[2]    = act;
    s[1]    = (q.size() == 0);
    s[0]    = (q.size() == D);
    return s;
  endfunction

  function automatic logic m_tx();
    int slot;
    if (!act) return 1'b1;
    slot = pos / C;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return cur[slot-1];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      act = 1'b0;
      pos = 0;
      ovf = 1'b0;
      m_rdata = 32'h0;
    end else begin
      was_full = (q.size() == D);
      can_pop  = !act && (q.size() > 0);
      if (bus_re) m_rdata = (bus_addr == 4'h4) ? m_status() : 32'h0;
      if (act) begin
        if (pos == 10*C-1) act = 1'b0;
        else pos++;
      end else if (can_pop) begin
        cur = q.pop_front();
        act = 1'b1;
        pos = 0;
      end
      if (bus_we && bus_addr == 4'h0) begin
        if (was_full) ovf = 1'b1;
        else q.push_back(bus_wdata[7:0]);
      end
      if (bus_we && bus_addr == 4'h4 && bus_wdata[3]) ovf = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_uart_tx", {31'b0, uart_tx}, {31'b0, m_tx()});
      check("model_tx_irq", {31'b0, tx_irq}, {31'b0, (!act && q.size() == 0)});
      check("model_rdata", bus_rdata, m_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_re = 1'b1; bus_addr = a;
    tick();
    bus_re = 1'b0; bus_addr = 4'h0;
    d = bus_rdata;
  endtask

  logic [31:0] rd;
  logic [9:0]  pat55;
  int          lowcnt;
  bit          found;

  initial begin
    pat55 = 10'h2AA;  // symbols 0,1,0,1,0,1,0,1,0,1 for 0x55
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("reset_irq", {31'b0, tx_irq}, 32'h1);
    check("reset_rdata", bus_rdata, 32'h0);

    // Register reads after reset
    bus_read(4'h4, rd); check("status_after_reset", rd, 32'h0000_0002);
    bus_read(4'h0, rd); check("read_txdata", rd, 32'h0);
    bus_read(4'h4, rd);
    bus_read(4'hC, rd); check("read_unmapped", rd, 32'h0);

    // Single 0x55 frame, pattern pinned literally
    bus_write(4'h0, 32'hFFFF_FF55);
    @(negedge clk);
    check("tx_high_before_pop", {31'b0, uart_tx}, 32'h1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("frame55_bit", {31'b0, uart_tx}, {31'b0, pat55[k/4]});
    end
    @(negedge clk);
    check("irq_after_stop", {31'b0, tx_irq}, 32'h1);

    // Back-to-back writes
    bus_write(4'h0, 32'hA5);
    bus_write(4'h0, 32'h3C);
    bus_write(4'h0, 32'hFF);
    bus_read(4'h4, rd); check("status_count2", rd, 32'h0000_0204);
    repeat (3*41 + 20) tick();
    check("irq_after_three", {31'b0, tx_irq}, 32'h1);

    // Overflow: six consecutive writes
    for (int i = 0; i < 6; i++) bus_write(4'h0, 32'(8'h10 + i));
    bus_read(4'h4, rd); check("status_full_ovf", rd, 32'h0000_040D);
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, rd); check("status_ovf_cleared", rd, 32'h0000_0405);
    repeat (5*41 + 20) tick();
    check("irq_after_drain", {31'b0, tx_irq}, 32'h1);

    // Reset during data bit 3 of 0x0F
    bus_write(4'h0, 32'h0F);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (act && pos == 17) found = 1'b1;
    end
    check("wait_data_bit3", {31'b0, found}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("tx_after_reset", {31'b0, uart_tx}, 32'h1);
    bus_read(4'h4, rd); check("status_after_midreset", rd, 32'h0000_0002);
    lowcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lowcnt++;
    end
    check("no_frame_after_reset", 32'(lowcnt), 32'h0);

    // Full FIFO, write lands on the pop cycle following STOP
    for (int i = 0; i < 5; i++) bus_write(4'h0, 32'(8'h11 * (i + 1)));
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (!act && q.size() > 0) found = 1'b1;
    end
    check("wait_pop_cycle", {31'b0, found}, 32'h1);
    bus_write(4'h0, 32'h66);
    bus_read(4'h4, rd); check("status_pop_cycle_drop", rd, 32'h0000_030C);
    repeat (4*41 + 20) tick();
    check("irq_final", {31'b0, tx_irq}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
